id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
- Pipeline register between instruction decode and execute.
- Captures the decoded instruction and the forwarded operands produced in decode.
- Inserts a bubble when decode's load-use stall is raised, and holds on an execute-side stall.
- Flushes on a redirect, and counts load-use bubbles for performance monitoring.

Parameters:
- DATA_WIDTH, 32, width of operands, PC, immediate and write data.
- ADDR_WIDTH, 5, register address width.
- OP_WIDTH, 8, width of the encoded execute operation.
- CNT_WIDTH, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  redirect/exception flush; kills the ID and EX contents
- ex_stall_i  in  1  execute cannot accept a new instruction this cycle
- fwd_stall_i  in  1  load-use hazard from decode's forwarding logic
- id_valid_i  in  1  decode holds a valid instruction
- id_pc_i  in  DATA_WIDTH  PC of the decode instruction
- id_op_i  in  OP_WIDTH  operation code
- id_rs_data_i  in  DATA_WIDTH  forwarded operand A
- id_rt_data_i  in  DATA_WIDTH  forwarded operand B
- id_imm_i  in  DATA_WIDTH  extended immediate
- id_waddr_i  in  ADDR_WIDTH  destination register
- id_we_i  in  1  register write enable
- id_mem_read_i  in  1  load
- id_mem_write_i  in  1  store
- cnt_clear_i  in  1  synchronous clear of the bubble counter
- id_stall_o  out  1  hold IF/ID this cycle
- ex_valid_o  out  1  EX register holds a real instruction
- ex_bubble_o  out  1  EX register holds an inserted load-use bubble
- ex_pc_o  out  DATA_WIDTH  registered PC
- ex_op_o  out  OP_WIDTH  registered operation code
- ex_rs_data_o  out  DATA_WIDTH  registered operand A
- ex_rt_data_o  out  DATA_WIDTH  registered operand B
- ex_imm_o  out  DATA_WIDTH  registered immediate
- ex_waddr_o  out  ADDR_WIDTH  registered destination (fed back to forwarding)
- ex_we_o  out  1  registered write enable, gated by valid
- ex_mem_read_o  out  1  registered load flag, gated by valid
- ex_mem_write_o  out  1  registered store flag, gated by valid
- bubble_cnt_o  out  CNT_WIDTH  saturating count of load-use bubbles

Behaviour:
- Reset (rst_n low, asynchronous): all ex_* outputs 0 and bubble_cnt_o 0. ex_we_o, ex_mem_read_o and ex_mem_write_o are 0, so forwarding sees no producer.
- Per-cycle priority at the rising edge:
  1. flush_i
  2. ex_stall_i
  3. fwd_stall_i
  4. advance
- FLUSH: ex_valid_o, ex_bubble_o, ex_we_o, ex_mem_read_o and ex_mem_write_o become 0. The data fields are don't-care but held. The flush wins even when ex_stall_i=1.
- HOLD (ex_stall_i=1, no flush): all EX registers keep their value; id_stall_o=1.
- BUBBLE (fwd_stall_i=1, id_valid_i=1, no flush/hold): EX loads ex_valid_o=0, ex_bubble_o=1, and all enables 0; id_stall_o=1.
  - bubble_cnt_o increments by 1 and saturates at all-ones; no wrap.
- ADVANCE: EX loads every id_* field and sets ex_valid_o=id_valid_i, ex_bubble_o=0. The enables are the id_* enables ANDed with id_valid_i.
- fwd_stall_i with id_valid_i=0 is ignored and treated as ADVANCE of an invalid slot; no count.
- id_stall_o (combinational):
  - equals ex_stall_i | (fwd_stall_i & id_valid_i), masked to 0 when flush_i=1.
  - No combinational path from flush_i or fwd_stall_i to any ex_* output.
- Latency: exactly 1 cycle from an ID field to the matching ex_* field when advancing.
- A load-use bubble lasts 1 cycle. The next cycle, the load occupies the stage after EX, decode re-evaluates, and fwd_stall_i deasserts.
- Counter rules:
  - cnt_clear_i has priority over increment; clear and bubble in the same cycle gives 0.
  - The counter does not change during HOLD or FLUSH.
- A reset asserted mid-stall returns to the reset state immediately. The first post-reset cycle with no stall advances normally.

Test Plan:
- Reset then advance: id_pc_i=0x1000, id_we_i=1, id_waddr_i=3, id_valid_i=1 → next cycle ex_pc_o=0x1000, ex_we_o=1, ex_waddr_o=3, ex_valid_o=1.
- Load-use: assert fwd_stall_i=1 for 1 cycle with a valid ID instruction → id_stall_o=1 that cycle; next cycle ex_valid_o=0, ex_bubble_o=1, ex_we_o=0, bubble_cnt_o=1; the following cycle the held ID instruction advances.
- Hold: ex_stall_i=1 for 3 cycles with ID inputs changing → EX outputs unchanged and id_stall_o=1 for all 3 cycles; bubble_cnt_o unchanged.
- Flush priority: flush_i=1 together with ex_stall_i=1 and fwd_stall_i=1 → id_stall_o=0; next cycle ex_valid_o=0, ex_bubble_o=0, all enables 0, counter unchanged.
- Saturation and clear: preload the counter to 0xFFFF, then force a bubble → it stays 0xFFFF. Assert cnt_clear_i with a bubble in the same cycle → 0.
- Async reset: drop rst_n between clock edges during HOLD → ex_valid_o and ex_we_o go 0 before the next clk edge; bubble_cnt_o=0.

Source files
------------

// File: rtl/id_ex_pipe_if.sv
// rtl/id_ex_pipe_if.sv - ID/EX pipeline register bus: decode-side inputs, execute-side outputs
interface id_ex_pipe_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int OP_WIDTH   = 8,
   parameter int CNT_WIDTH  = 16
);
   logic                  flush_i;
   logic                  ex_stall_i;
   logic                  fwd_stall_i;
   logic                  id_valid_i;
   logic [DATA_WIDTH-1:0] id_pc_i;
   logic [OP_WIDTH-1:0]   id_op_i;
   logic [DATA_WIDTH-1:0] id_rs_data_i;
   logic [DATA_WIDTH-1:0] id_rt_data_i;
   logic [DATA_WIDTH-1:0] id_imm_i;
   logic [ADDR_WIDTH-1:0] id_waddr_i;
   logic                  id_we_i;
   logic                  id_mem_read_i;
   logic                  id_mem_write_i;
   logic                  cnt_clear_i;
   logic                  id_stall_o;
   logic                  ex_valid_o;
   logic                  ex_bubble_o;
   logic [DATA_WIDTH-1:0] ex_pc_o;
   logic [OP_WIDTH-1:0]   ex_op_o;
   logic [DATA_WIDTH-1:0] ex_rs_data_o;
   logic [DATA_WIDTH-1:0] ex_rt_data_o;
   logic [DATA_WIDTH-1:0] ex_imm_o;
   logic [ADDR_WIDTH-1:0] ex_waddr_o;
   logic                  ex_we_o;
   logic                  ex_mem_read_o;
   logic                  ex_mem_write_o;
   logic [CNT_WIDTH-1:0]  bubble_cnt_o;

   // Decode/control side drives the pipe.
   modport master (
      output flush_i, ex_stall_i, fwd_stall_i, id_valid_i, id_pc_i, id_op_i,
             id_rs_data_i, id_rt_data_i, id_imm_i, id_waddr_i, id_we_i,
             id_mem_read_i, id_mem_write_i, cnt_clear_i,
      input  id_stall_o, ex_valid_o, ex_bubble_o, ex_pc_o, ex_op_o, ex_rs_data_o,
             ex_rt_data_o, ex_imm_o, ex_waddr_o, ex_we_o, ex_mem_read_o,
             ex_mem_write_o, bubble_cnt_o
   );

   // The pipeline register itself.
   modport slave (
      input  flush_i, ex_stall_i, fwd_stall_i, id_valid_i, id_pc_i, id_op_i,
             id_rs_data_i, id_rt_data_i, id_imm_i, id_waddr_i, id_we_i,
             id_mem_read_i, id_mem_write_i, cnt_clear_i,
      output id_stall_o, ex_valid_o, ex_bubble_o, ex_pc_o, ex_op_o, ex_rs_data_o,
             ex_rt_data_o, ex_imm_o, ex_waddr_o, ex_we_o, ex_mem_read_o,
             ex_mem_write_o, bubble_cnt_o
   );
endinterface

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with load-use bubble, hold, flush and bubble counter
module id_ex_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int OP_WIDTH   = 8,
   parameter int CNT_WIDTH  = 16
) (
   input logic         clk,
   input logic         rst_n,
   id_ex_pipe_if.slave bus
);
   logic                  ex_valid_q,  ex_valid_d;
   logic                  ex_bubble_q, ex_bubble_d;
   logic [DATA_WIDTH-1:0] ex_pc_q,     ex_pc_d;
   logic [OP_WIDTH-1:0]   ex_op_q,     ex_op_d;
   logic [DATA_WIDTH-1:0] ex_rs_q,     ex_rs_d;
   logic [DATA_WIDTH-1:0] ex_rt_q,     ex_rt_d;
   logic [DATA_WIDTH-1:0] ex_imm_q,    ex_imm_d;
   logic [ADDR_WIDTH-1:0] ex_waddr_q,  ex_waddr_d;
   logic                  ex_we_q,     ex_we_d;
   logic                  ex_mrd_q,    ex_mrd_d;
   logic                  ex_mwr_q,    ex_mwr_d;
   logic [CNT_WIDTH-1:0]  cnt_q,       cnt_d;

   logic take_bubble;
   logic hold;

   // Flush outranks hold, hold outranks the load-use bubble; an invalid slot never bubbles.
   assign hold        = ~bus.flush_i & bus.ex_stall_i;
   assign take_bubble = ~bus.flush_i & ~bus.ex_stall_i & bus.fwd_stall_i & bus.id_valid_i;

   // IF/ID is held while EX holds or while a bubble is inserted, never during a flush.
   assign bus.id_stall_o = ~bus.flush_i & (bus.ex_stall_i | (bus.fwd_stall_i & bus.id_valid_i));

   // Next EX contents: data fields are kept on flush/bubble so only control bits toggle.
   always_comb begin
      ex_valid_d  = ex_valid_q;
      ex_bubble_d = ex_bubble_q;
      ex_pc_d     = ex_pc_q;
      ex_op_d     = ex_op_q;
      ex_rs_d     = ex_rs_q;
      ex_rt_d     = ex_rt_q;
      ex_imm_d    = ex_imm_q;
      ex_waddr_d  = ex_waddr_q;
      ex_we_d     = ex_we_q;
      ex_mrd_d    = ex_mrd_q;
      ex_mwr_d    = ex_mwr_q;
      if (bus.flush_i || take_bubble) begin
         ex_valid_d  = 1'b0;
         ex_bubble_d = take_bubble;
         ex_we_d     = 1'b0;
         ex_mrd_d    = 1'b0;
         ex_mwr_d    = 1'b0;
      end else if (!hold) begin
         ex_valid_d  = bus.id_valid_i;
         ex_bubble_d = 1'b0;
         ex_pc_d     = bus.id_pc_i;
         ex_op_d     = bus.id_op_i;
         ex_rs_d     = bus.id_rs_data_i;
         ex_rt_d     = bus.id_rt_data_i;
         ex_imm_d    = bus.id_imm_i;
         ex_waddr_d  = bus.id_waddr_i;
         ex_we_d     = bus.id_we_i & bus.id_valid_i;
         ex_mrd_d    = bus.id_mem_read_i & bus.id_valid_i;
         ex_mwr_d    = bus.id_mem_write_i & bus.id_valid_i;
      end
   end

   // Bubble counter: clear wins over increment, and it sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (bus.cnt_clear_i) begin
         cnt_d = '0;
      end else if (take_bubble && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // EX register bank and counter state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q  <= 1'b0;
         ex_bubble_q <= 1'b0;
         ex_pc_q     <= '0;
         ex_op_q     <= '0;
         ex_rs_q     <= '0;
         ex_rt_q     <= '0;
         ex_imm_q    <= '0;
         ex_waddr_q  <= '0;
         ex_we_q     <= 1'b0;
         ex_mrd_q    <= 1'b0;
         ex_mwr_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_bubble_q <= ex_bubble_d;
         ex_pc_q     <= ex_pc_d;
         ex_op_q     <= ex_op_d;
         ex_rs_q     <= ex_rs_d;
         ex_rt_q     <= ex_rt_d;
         ex_imm_q    <= ex_imm_d;
         ex_waddr_q  <= ex_waddr_d;
         ex_we_q     <= ex_we_d;
         ex_mrd_q    <= ex_mrd_d;
         ex_mwr_q    <= ex_mwr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.ex_valid_o     = ex_valid_q;
   assign bus.ex_bubble_o    = ex_bubble_q;
   assign bus.ex_pc_o        = ex_pc_q;
   assign bus.ex_op_o        = ex_op_q;
   assign bus.ex_rs_data_o   = ex_rs_q;
   assign bus.ex_rt_data_o   = ex_rt_q;
   assign bus.ex_imm_o       = ex_imm_q;
   assign bus.ex_waddr_o     = ex_waddr_q;
   assign bus.ex_we_o        = ex_we_q;
   assign bus.ex_mem_read_o  = ex_mrd_q;
   assign bus.ex_mem_write_o = ex_mwr_q;
   assign bus.bubble_cnt_o   = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - randomized and directed bench for id_ex_pipe against a behavioural model
module tb_id_ex_pipe;
   logic clk;
   logic rst_n;

   id_ex_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .OP_WIDTH(8), .CNT_WIDTH(16)) bus ();

   id_ex_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .OP_WIDTH(8), .CNT_WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: what the EX stage should hold, per the stage rules.
   typedef struct {
      bit          valid;
      bit          bubble;
      bit          we;
      bit          mrd;
      bit          mwr;
      logic [31:0] pc;
      logic [7:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [4:0]  waddr;
   } ex_t;

   ex_t         m;
   int unsigned m_cnt;
   bit          m_is_bubble;

   // Model update on each clock edge (or asynchronous reset).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m     = '{default: 0};
         m_cnt = 0;
      end else begin
         m_is_bubble = !bus.flush_i && !bus.ex_stall_i && bus.fwd_stall_i && bus.id_valid_i;
         if (bus.cnt_clear_i)                      m_cnt = 0;
         else if (m_is_bubble && m_cnt < 65535)    m_cnt = m_cnt + 1;
         if (bus.flush_i) begin
            m.valid = 0; m.bubble = 0; m.we = 0; m.mrd = 0; m.mwr = 0;
         end else if (bus.ex_stall_i) begin
            // stage frozen
         end else if (m_is_bubble) begin
            m.valid = 0; m.bubble = 1; m.we = 0; m.mrd = 0; m.mwr = 0;
         end else begin
            m.valid  = bus.id_valid_i;
            m.bubble = 0;
            m.we     = bus.id_we_i && bus.id_valid_i;
            m.mrd    = bus.id_mem_read_i && bus.id_valid_i;
            m.mwr    = bus.id_mem_write_i && bus.id_valid_i;
            m.pc     = bus.id_pc_i;
            m.op     = bus.id_op_i;
            m.rs     = bus.id_rs_data_i;
            m.rt     = bus.id_rt_data_i;
            m.imm    = bus.id_imm_i;
            m.waddr  = bus.id_waddr_i;
         end
      end
   end

   // Compare process: every falling edge out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("id_stall", bus.id_stall_o,
             !bus.flush_i && (bus.ex_stall_i || (bus.fwd_stall_i && bus.id_valid_i)));
         chk("ex_valid",  bus.ex_valid_o,     m.valid);
         chk("ex_bubble", bus.ex_bubble_o,    m.bubble);
         chk("ex_we",     bus.ex_we_o,        m.we);
         chk("ex_mrd",    bus.ex_mem_read_o,  m.mrd);
         chk("ex_mwr",    bus.ex_mem_write_o, m.mwr);
         chk("bub_cnt",   bus.bubble_cnt_o,   m_cnt);
         if (m.valid) begin
            chk("ex_pc",    bus.ex_pc_o,      m.pc);
            chk("ex_op",    bus.ex_op_o,      m.op);
            chk("ex_rs",    bus.ex_rs_data_o, m.rs);
            chk("ex_rt",    bus.ex_rt_data_o, m.rt);
            chk("ex_imm",   bus.ex_imm_o,     m.imm);
            chk("ex_waddr", bus.ex_waddr_o,   m.waddr);
         end
      end
   end

   task automatic idle();
      bus.flush_i = 0; bus.ex_stall_i = 0; bus.fwd_stall_i = 0; bus.id_valid_i = 0;
      bus.id_pc_i = 0; bus.id_op_i = 0; bus.id_rs_data_i = 0; bus.id_rt_data_i = 0;
      bus.id_imm_i = 0; bus.id_waddr_i = 0; bus.id_we_i = 0; bus.id_mem_read_i = 0;
      bus.id_mem_write_i = 0; bus.cnt_clear_i = 0;
   endtask

   task automatic next_drive();
      @(negedge clk);
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      rst_n = 0;
      idle();
      repeat (2) @(negedge clk);
      chk("rst_valid", bus.ex_valid_o, 0);
      chk("rst_we",    bus.ex_we_o,    0);
      chk("rst_cnt",   bus.bubble_cnt_o, 0);
      chk("rst_pc",    bus.ex_pc_o,    0);
      #1 rst_n = 1;

      // Reset then advance.
      bus.id_valid_i = 1; bus.id_pc_i = 32'h1000; bus.id_we_i = 1; bus.id_waddr_i = 3;
      @(negedge clk);
      chk("adv_pc",    bus.ex_pc_o,    32'h1000);
      chk("adv_we",    bus.ex_we_o,    1);
      chk("adv_waddr", bus.ex_waddr_o, 3);
      chk("adv_valid", bus.ex_valid_o, 1);

      // Load-use bubble, then the held instruction advances.
      #1 bus.fwd_stall_i = 1; bus.id_pc_i = 32'h2000; bus.id_mem_read_i = 1;
      #1 chk("lu_idstall", bus.id_stall_o, 1);
      @(negedge clk);
      chk("lu_valid",  bus.ex_valid_o,  0);
      chk("lu_bubble", bus.ex_bubble_o, 1);
      chk("lu_we",     bus.ex_we_o,     0);
      chk("lu_cnt",    bus.bubble_cnt_o, 1);
      #1 bus.fwd_stall_i = 0;
      @(negedge clk);
      chk("lu_pc2",    bus.ex_pc_o,     32'h2000);
      chk("lu_valid2", bus.ex_valid_o,  1);
      chk("lu_mrd2",   bus.ex_mem_read_o, 1);

      // Hold for 3 cycles while ID changes underneath.
      for (int i = 0; i < 3; i++) begin
         #1 bus.ex_stall_i = 1; bus.id_pc_i = $urandom; bus.id_we_i = 0;
         #1 chk("hold_idstall", bus.id_stall_o, 1);
         @(negedge clk);
         chk("hold_pc",  bus.ex_pc_o,      32'h2000);
         chk("hold_cnt", bus.bubble_cnt_o, 1);
      end

      // Flush beats hold and bubble.
      #1 bus.flush_i = 1; bus.fwd_stall_i = 1; bus.id_valid_i = 1;
      #1 chk("fl_idstall", bus.id_stall_o, 0);
      @(negedge clk);
      chk("fl_valid",  bus.ex_valid_o,    0);
      chk("fl_bubble", bus.ex_bubble_o,   0);
      chk("fl_mrd",    bus.ex_mem_read_o, 0);
      chk("fl_cnt",    bus.bubble_cnt_o,  1);

      // Asynchronous reset in the middle of a hold.
      #1 idle(); bus.id_valid_i = 1; bus.id_we_i = 1; bus.id_pc_i = 32'h4000;
      @(negedge clk);
      chk("pre_rst_valid", bus.ex_valid_o, 1);
      #1 bus.ex_stall_i = 1;
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("arst_valid", bus.ex_valid_o,   0);
      chk("arst_we",    bus.ex_we_o,      0);
      chk("arst_cnt",   bus.bubble_cnt_o, 0);
      @(negedge clk);
      #1 rst_n = 1; bus.ex_stall_i = 0; bus.id_pc_i = 32'h3000;
      @(negedge clk);
      chk("post_rst_pc",    bus.ex_pc_o,    32'h3000);
      chk("post_rst_valid", bus.ex_valid_o, 1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         #1;
         bus.flush_i        = ($urandom_range(0, 15) == 0);
         bus.ex_stall_i     = ($urandom_range(0, 5) == 0);
         bus.fwd_stall_i    = ($urandom_range(0, 3) == 0);
         bus.id_valid_i     = ($urandom_range(0, 3) != 0);
         bus.cnt_clear_i    = ($urandom_range(0, 31) == 0);
         bus.id_pc_i        = $urandom;
         bus.id_op_i        = 8'($urandom);
         bus.id_rs_data_i   = $urandom;
         bus.id_rt_data_i   = $urandom;
         bus.id_imm_i       = $urandom;
         bus.id_waddr_i     = 5'($urandom);
         bus.id_we_i        = 1'($urandom);
         bus.id_mem_read_i  = 1'($urandom);
         bus.id_mem_write_i = 1'($urandom);
         @(negedge clk);
      end

      // Clear together with a bubble yields 0, then saturate.
      #1 idle(); bus.id_valid_i = 1; bus.fwd_stall_i = 1; bus.cnt_clear_i = 1;
      @(negedge clk);
      chk("clr_bub_cnt", bus.bubble_cnt_o, 0);
      #1 bus.cnt_clear_i = 0;
      repeat (65535) @(negedge clk);
      chk("sat_cnt", bus.bubble_cnt_o, 16'hFFFF);
      chk("sat_model", m_cnt, 65535);
      @(negedge clk);
      chk("sat_hold_cnt", bus.bubble_cnt_o, 16'hFFFF);
      #1 bus.cnt_clear_i = 1;
      @(negedge clk);
      chk("sat_clr_cnt", bus.bubble_cnt_o, 0);
      #1 idle();
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
